// File: rtl/mul_arb_pkg.sv
// Shared op codes, FSM states and operand sign rules for the mul_arb slice.
package mul_arb_pkg;

    typedef enum logic [1:0] {
        OP_MUL    = 2'b00,
        OP_MULH   = 2'b01,
        OP_MULHSU = 2'b10,
        OP_MULHU  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    function automatic logic op_a_signed(op_e op);
        return op != OP_MULHU;
    endfunction

    function automatic logic op_b_signed(op_e op);
        return (op == OP_MUL) || (op == OP_MULH);
    endfunction

endpackage

// File: rtl/mul_sign_fix.sv
// Maps signed operands onto an unsigned multiplier: magnitudes out,
// and the raw product back to a sign-corrected, op-selected result.
module mul_sign_fix
    import mul_arb_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  op_e               op_i,
    input  logic [XLEN-1:0]   a_i,
    input  logic [XLEN-1:0]   b_i,
    input  logic [2*XLEN-1:0] product_i,
    output logic [XLEN-1:0]   mag_a_o,
    output logic [XLEN-1:0]   mag_b_o,
    output logic [XLEN-1:0]   result_o
);

    logic              neg_a;
    logic              neg_b;
    logic              neg;
    logic [2*XLEN-1:0] prod_fix;

    always_comb begin
        neg_a    = op_a_signed(op_i) & a_i[XLEN-1];
        neg_b    = op_b_signed(op_i) & b_i[XLEN-1];
        // Negating the most negative value wraps to itself, which read as
        // unsigned is exactly its magnitude.
        mag_a_o  = neg_a ? -a_i : a_i;
        mag_b_o  = neg_b ? -b_i : b_i;
        neg      = neg_a ^ neg_b;
        prod_fix = neg ? -product_i : product_i;
        result_o = (op_i == OP_MUL) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];
    end

endmodule

// File: rtl/mul_arb.sv
// Two-requester round-robin front end for one shared unsigned multiplier.
// Optional MUL_ARB_ZERO_SKIP_EN: a zero operand bypasses the multiplier.
module mul_arb
    import mul_arb_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req0_valid_i,
    output logic              req0_ready_o,
    input  logic [1:0]        req0_op_i,
    input  logic [XLEN-1:0]   req0_a_i,
    input  logic [XLEN-1:0]   req0_b_i,
    input  logic              req1_valid_i,
    output logic              req1_ready_o,
    input  logic [1:0]        req1_op_i,
    input  logic [XLEN-1:0]   req1_a_i,
    input  logic [XLEN-1:0]   req1_b_i,
    output logic              resp0_valid_o,
    output logic [XLEN-1:0]   resp0_data_o,
    output logic              resp1_valid_o,
    output logic [XLEN-1:0]   resp1_data_o,
    output logic              mul_req_o,
    output logic [XLEN-1:0]   mul_a_o,
    output logic [XLEN-1:0]   mul_b_o,
    input  logic              mul_ready_i,
    input  logic [2*XLEN-1:0] mul_result_i
);

    state_e          state_q, state_d;
    logic            last_grant_q, last_grant_d;
    logic            gnt_id_q, gnt_id_d;
    op_e             op_q, op_d;
    logic [XLEN-1:0] a_q, a_d;
    logic [XLEN-1:0] b_q, b_d;
    logic            mul_req_q, mul_req_d;
    logic            resp0_valid_q, resp0_valid_d;
    logic            resp1_valid_q, resp1_valid_d;
    logic [XLEN-1:0] resp0_data_q, resp0_data_d;
    logic [XLEN-1:0] resp1_data_q, resp1_data_d;

    logic            grant_any;
    logic            grant_sel;
    logic [1:0]      sel_op;
    logic [XLEN-1:0] sel_a;
    logic [XLEN-1:0] sel_b;
    logic [XLEN-1:0] mag_a;
    logic [XLEN-1:0] mag_b;
    logic [XLEN-1:0] fix_result;

    always_comb begin
        grant_any = req0_valid_i | req1_valid_i;
        grant_sel = (req0_valid_i & req1_valid_i) ? ~last_grant_q : req1_valid_i;
        sel_op    = grant_sel ? req1_op_i : req0_op_i;
        sel_a     = grant_sel ? req1_a_i  : req0_a_i;
        sel_b     = grant_sel ? req1_b_i  : req0_b_i;
    end

    // A grant made while reset is asserted would be lost, so hide it.
    assign req0_ready_o = (state_q == ST_IDLE) & ~rst_i & grant_any & ~grant_sel;
    assign req1_ready_o = (state_q == ST_IDLE) & ~rst_i & grant_any &  grant_sel;

    mul_sign_fix #(
        .XLEN(XLEN)
    ) u_sign_fix (
        .op_i      (op_q),
        .a_i       (a_q),
        .b_i       (b_q),
        .product_i (mul_result_i),
        .mag_a_o   (mag_a),
        .mag_b_o   (mag_b),
        .result_o  (fix_result)
    );

    always_comb begin
        state_d       = state_q;
        last_grant_d  = last_grant_q;
        gnt_id_d      = gnt_id_q;
        op_d          = op_q;
        a_d           = a_q;
        b_d           = b_q;
        mul_req_d     = 1'b0;
        resp0_valid_d = 1'b0;
        resp1_valid_d = 1'b0;
        resp0_data_d  = resp0_data_q;
        resp1_data_d  = resp1_data_q;
        unique case (state_q)
            ST_IDLE: begin
                if (grant_any) begin
                    last_grant_d = grant_sel;
                    gnt_id_d     = grant_sel;
                    op_d         = op_e'(sel_op);
                    a_d          = sel_a;
                    b_d          = sel_b;
                    state_d      = ST_BUSY;
                    mul_req_d    = 1'b1;
`ifdef MUL_ARB_ZERO_SKIP_EN
                    if ((sel_a == '0) || (sel_b == '0)) begin
                        state_d   = ST_RESP;
                        mul_req_d = 1'b0;
                        if (grant_sel) begin
                            resp1_valid_d = 1'b1;
                            resp1_data_d  = '0;
                        end else begin
                            resp0_valid_d = 1'b1;
                            resp0_data_d  = '0;
                        end
                    end
`endif
                end
            end
            ST_BUSY: begin
                if (mul_ready_i) begin
                    state_d = ST_RESP;
                    if (gnt_id_q) begin
                        resp1_valid_d = 1'b1;
                        resp1_data_d  = fix_result;
                    end else begin
                        resp0_valid_d = 1'b1;
                        resp0_data_d  = fix_result;
                    end
                end else begin
                    mul_req_d = 1'b1;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q       <= ST_IDLE;
            last_grant_q  <= 1'b1;
            gnt_id_q      <= 1'b0;
            op_q          <= OP_MUL;
            a_q           <= '0;
            b_q           <= '0;
            mul_req_q     <= 1'b0;
            resp0_valid_q <= 1'b0;
            resp1_valid_q <= 1'b0;
            resp0_data_q  <= '0;
            resp1_data_q  <= '0;
        end else begin
            state_q       <= state_d;
            last_grant_q  <= last_grant_d;
            gnt_id_q      <= gnt_id_d;
            op_q          <= op_d;
            a_q           <= a_d;
            b_q           <= b_d;
            mul_req_q     <= mul_req_d;
            resp0_valid_q <= resp0_valid_d;
            resp1_valid_q <= resp1_valid_d;
            resp0_data_q  <= resp0_data_d;
            resp1_data_q  <= resp1_data_d;
        end
    end

    assign mul_req_o     = mul_req_q;
    assign mul_a_o       = mag_a;
    assign mul_b_o       = mag_b;
    assign resp0_valid_o = resp0_valid_q;
    assign resp1_valid_o = resp1_valid_q;
    assign resp0_data_o  = resp0_data_q;
    assign resp1_data_o  = resp1_data_q;

endmodule

// File: tb/tb_mul_arb.sv
// Bench for mul_arb: behavioural multiplier with programmable latency and a
// transaction-level reference model checked on every falling clock edge.
module tb_mul_arb;
    import mul_arb_pkg::*;

    localparam int XLEN = 32;

    typedef struct packed {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
    } txn_t;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        req0_valid_i, req1_valid_i;
    logic        req0_ready_o, req1_ready_o;
    logic [1:0]  req0_op_i, req1_op_i;
    logic [31:0] req0_a_i, req0_b_i, req1_a_i, req1_b_i;
    logic        resp0_valid_o, resp1_valid_o;
    logic [31:0] resp0_data_o, resp1_data_o;
    logic        mul_req_o;
    logic [31:0] mul_a_o, mul_b_o;
    logic        mul_ready_i;
    logic [63:0] mul_result_i;

    always #5 clk = ~clk;

    mul_arb #(.XLEN(XLEN)) dut (
        .clk_i(clk), .rst_i(rst_i),
        .req0_valid_i(req0_valid_i), .req0_ready_o(req0_ready_o), .req0_op_i(req0_op_i),
        .req0_a_i(req0_a_i), .req0_b_i(req0_b_i),
        .req1_valid_i(req1_valid_i), .req1_ready_o(req1_ready_o), .req1_op_i(req1_op_i),
        .req1_a_i(req1_a_i), .req1_b_i(req1_b_i),
        .resp0_valid_o(resp0_valid_o), .resp0_data_o(resp0_data_o),
        .resp1_valid_o(resp1_valid_o), .resp1_data_o(resp1_data_o),
        .mul_req_o(mul_req_o), .mul_a_o(mul_a_o), .mul_b_o(mul_b_o),
        .mul_ready_i(mul_ready_i), .mul_result_i(mul_result_i)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int lat     = 2;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: widen with sign or zero extension and multiply exactly.
    function automatic logic [31:0] ref_mul(input logic [1:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        logic signed [65:0] sa, sb, p;
        sa = (op == 2'b11) ? $signed({34'd0, a}) : $signed({{34{a[31]}}, a});
        sb = (op[1] == 1'b1) ? $signed({34'd0, b}) : $signed({{34{b[31]}}, b});
        p  = sa * sb;
        return (op == 2'b00) ? p[31:0] : p[63:32];
    endfunction

    function automatic logic [31:0] mag(input logic [31:0] x, input logic sgn);
        return (sgn && x[31]) ? (32'd0 - x) : x;
    endfunction

    // Stand-in multiplier: result valid in the lat-th consecutive cycle of mul_req_o.
    int mcnt = 0;
    initial begin
        mul_ready_i  = 1'b0;
        mul_result_i = '0;
        forever begin
            @(posedge clk);
            #1;
            if (mul_req_o) begin
                mcnt++;
                mul_ready_i  = (mcnt == lat);
                mul_result_i = {32'd0, mul_a_o} * {32'd0, mul_b_o};
            end else begin
                mcnt        = 0;
                mul_ready_i = 1'b0;
            end
        end
    end

    // Model state: one operation in flight at most, timed from its accept cycle.
    logic        m_last = 1'b1;
    int          free_at = 0;
    logic        p_valid = 1'b0;
    logic        p_id = 1'b0;
    logic [31:0] p_data = '0;
    int          p_due = 0;
    int          win_lo = 1, win_hi = 0;
    logic [31:0] m_data0 = '0, m_data1 = '0;
    logic [31:0] m_mag_a = '0, m_mag_b = '0;
    logic        e_r0, e_r1, e_v0, e_v1, e_req, gid, zs, prev_req = 1'b0;
    logic [1:0]  t_op;
    logic [31:0] t_a, t_b;

    int          acc0_cnt = 0, acc1_cnt = 0, resp_count = 0;
    logic        grant_log[$];
    logic [31:0] mul_a_log[$], mul_b_log[$];

    always @(negedge clk) begin
        cyc++;
        e_r0 = 1'b0;
        e_r1 = 1'b0;
        gid  = 1'b0;
        if (!rst_i && cyc >= free_at && (req0_valid_i || req1_valid_i)) begin
            gid = (req0_valid_i && req1_valid_i) ? ~m_last : req1_valid_i;
            if (gid) e_r1 = 1'b1;
            else     e_r0 = 1'b1;
        end
        chk("req0_ready", req0_ready_o, e_r0);
        chk("req1_ready", req1_ready_o, e_r1);

        e_v0 = p_valid && (p_due == cyc) && !p_id;
        e_v1 = p_valid && (p_due == cyc) &&  p_id;
        chk("resp0_valid", resp0_valid_o, e_v0);
        chk("resp1_valid", resp1_valid_o, e_v1);
        chk("resp_exclusive", resp0_valid_o & resp1_valid_o, 1'b0);
        if (e_v0) m_data0 = p_data;
        if (e_v1) m_data1 = p_data;
        if (e_v0 || e_v1) p_valid = 1'b0;
        chk("resp0_data", resp0_data_o, m_data0);
        chk("resp1_data", resp1_data_o, m_data1);

        e_req = (cyc >= win_lo) && (cyc <= win_hi);
        chk("mul_req", mul_req_o, e_req);
        if (e_req) begin
            chk("mul_a", mul_a_o, m_mag_a);
            chk("mul_b", mul_b_o, m_mag_b);
        end

        if (mul_req_o && !prev_req) begin
            mul_a_log.push_back(mul_a_o);
            mul_b_log.push_back(mul_b_o);
        end
        prev_req = mul_req_o;
        if (resp0_valid_o || resp1_valid_o) resp_count++;
        if (req0_valid_i && req0_ready_o) begin acc0_cnt++; grant_log.push_back(1'b0); end
        if (req1_valid_i && req1_ready_o) begin acc1_cnt++; grant_log.push_back(1'b1); end

        if (e_r0 || e_r1) begin
            t_op    = gid ? req1_op_i : req0_op_i;
            t_a     = gid ? req1_a_i  : req0_a_i;
            t_b     = gid ? req1_b_i  : req0_b_i;
            m_last  = gid;
            p_valid = 1'b1;
            p_id    = gid;
            p_data  = ref_mul(t_op, t_a, t_b);
            m_mag_a = mag(t_a, t_op != 2'b11);
            m_mag_b = mag(t_b, t_op[1] == 1'b0);
`ifdef MUL_ARB_ZERO_SKIP_EN
            zs = (t_a == 32'd0) || (t_b == 32'd0);
`else
            zs = 1'b0;
`endif
            if (zs) begin
                p_data  = '0;
                p_due   = cyc + 1;
                win_lo  = 1;
                win_hi  = 0;
                free_at = cyc + 2;
            end else begin
                p_due   = cyc + lat + 1;
                win_lo  = cyc + 1;
                win_hi  = cyc + lat;
                free_at = cyc + lat + 2;
            end
        end

        if (rst_i) begin
            p_valid = 1'b0;
            win_lo  = 1;
            win_hi  = 0;
            free_at = cyc + 1;
            m_last  = 1'b1;
            m_data0 = '0;
            m_data1 = '0;
        end
    end

    txn_t q0[$], q1[$];
    int   taken0 = 0, taken1 = 0;

    task automatic step();
        @(posedge clk);
        #1;
        while (taken0 < acc0_cnt) begin q0.delete(0); taken0++; end
        while (taken1 < acc1_cnt) begin q1.delete(0); taken1++; end
        if (q0.size() > 0) begin
            req0_valid_i = 1'b1;
            req0_op_i    = q0[0].op;
            req0_a_i     = q0[0].a;
            req0_b_i     = q0[0].b;
        end else begin
            req0_valid_i = 1'b0;
        end
        if (q1.size() > 0) begin
            req1_valid_i = 1'b1;
            req1_op_i    = q1[0].op;
            req1_a_i     = q1[0].a;
            req1_b_i     = q1[0].b;
        end else begin
            req1_valid_i = 1'b0;
        end
    endtask

    task automatic run(input int budget);
        int n;
        n = 0;
        step();
        while ((q0.size() > 0 || q1.size() > 0 || p_valid || free_at > cyc + 1) && n < budget) begin
            step();
            n++;
        end
        if (n >= budget) begin
            n_tests++;
            n_fail++;
            $display("FAIL run_timeout: still busy after %0d cycles (cycle %0d)", budget, cyc);
        end
    endtask

    int gstart, rc_before, k;

    initial begin
        rst_i        = 1'b1;
        req0_valid_i = 1'b0;
        req1_valid_i = 1'b0;
        req0_op_i    = '0;
        req1_op_i    = '0;
        req0_a_i     = '0;
        req0_b_i     = '0;
        req1_a_i     = '0;
        req1_b_i     = '0;
        repeat (3) step();
        rst_i = 1'b0;

        chk("pin_mul",    ref_mul(2'b00, 32'd7, 32'hFFFFFFFD), 32'hFFFFFFEB);
        chk("pin_mulh",   ref_mul(2'b01, 32'h80000000, 32'h80000000), 32'h40000000);
        chk("pin_mulhsu", ref_mul(2'b10, 32'hFFFFFFFF, 32'hFFFFFFFF), 32'hFFFFFFFF);
        chk("pin_mulhu",  ref_mul(2'b11, 32'hFFFFFFFF, 32'hFFFFFFFF), 32'hFFFFFFFE);

        lat = 2;
        q0.push_back('{op: 2'b00, a: 32'd7, b: 32'hFFFFFFFD});
        run(50);
        chk("lit_mul_data", resp0_data_o, 32'hFFFFFFEB);
        chk("lit_mul_a", (mul_a_log.size() > 0) ? mul_a_log[0] : 32'hDEAD, 32'd7);
        chk("lit_mul_b", (mul_b_log.size() > 0) ? mul_b_log[0] : 32'hDEAD, 32'd3);

        lat = 3;
        q1.push_back('{op: 2'b01, a: 32'h80000000, b: 32'h80000000});
        run(50);
        chk("lit_mulh_data", resp1_data_o, 32'h40000000);

        lat = 1;
        q0.push_back('{op: 2'b10, a: 32'hFFFFFFFF, b: 32'hFFFFFFFF});
        run(50);
        chk("lit_mulhsu_data", resp0_data_o, 32'hFFFFFFFF);
        q1.push_back('{op: 2'b11, a: 32'hFFFFFFFF, b: 32'hFFFFFFFF});
        run(50);
        chk("lit_mulhu_data", resp1_data_o, 32'hFFFFFFFE);

        rst_i = 1'b1;
        step();
        rst_i = 1'b0;
        lat = 2;
        gstart = grant_log.size();
        q0.push_back('{op: 2'b00, a: 32'hFFFFFFFB, b: 32'hFFFFFFFA});
        q0.push_back('{op: 2'b01, a: 32'h7FFFFFFF, b: 32'h80000000});
        q0.push_back('{op: 2'b10, a: 32'h80000000, b: 32'd3});
        q0.push_back('{op: 2'b11, a: 32'hDEADBEEF, b: 32'h12345678});
        q1.push_back('{op: 2'b01, a: 32'hFFFFFFFF, b: 32'hFFFFFFFF});
        q1.push_back('{op: 2'b00, a: 32'h00010000, b: 32'h00010000});
        q1.push_back('{op: 2'b10, a: 32'd5, b: 32'hFFFFFFFF});
        q1.push_back('{op: 2'b11, a: 32'hFFFFFFFF, b: 32'hFFFFFFFF});
        run(200);
        chk("tie_grant_count", grant_log.size() - gstart, 8);
        for (int i = 0; i < 8; i++) begin
            k = gstart + i;
            chk("tie_grant_order", (k < grant_log.size()) ? {63'd0, grant_log[k]} : 64'hBAD,
                i % 2);
        end

        lat = 2;
        q0.push_back('{op: 2'b00, a: 32'd0, b: 32'd12345});
        q1.push_back('{op: 2'b11, a: 32'd5, b: 32'd0});
        run(50);
        chk("zero_data0", resp0_data_o, 32'd0);
        chk("zero_data1", resp1_data_o, 32'd0);

        lat = 8;
        rc_before = resp_count;
        gstart = grant_log.size();
        q0.push_back('{op: 2'b00, a: 32'd3, b: 32'd4});
        k = 0;
        while (grant_log.size() == gstart && k < 20) begin
            step();
            k++;
        end
        step();
        step();
        rst_i = 1'b1;
        step();
        rst_i = 1'b0;
        repeat (12) step();
        chk("rst_no_resp", resp_count - rc_before, 0);
        chk("rst_mul_req", mul_req_o, 1'b0);
        chk("rst_data0", resp0_data_o, 32'd0);

        lat = 2;
        q1.push_back('{op: 2'b00, a: 32'd6, b: 32'd7});
        run(50);
        chk("post_rst_data1", resp1_data_o, 32'd42);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: bench did not finish (cycle %0d)", cyc);
        $fatal(1);
    end

endmodule

// File: doc/mul_arb.md
MUL_ARB -- requirements
Module: mul_arb

Interface
REQ-001 SHALL have parameter XLEN, default 32, operand width; the multiplier result width is 2*XLEN.
REQ-002 SHALL have ports, clock and reset first:
- clk_i  input  1  single clock.
- rst_i  input  1  reset, synchronous, active-high.
- reqN_valid_i  input  1  requester N (N=0,1) has a pending multiply.
- reqN_ready_o  output  1  requester N accepted this cycle.
- reqN_op_i  input  2  op code: 00 MUL, 01 MULH, 10 MULHSU, 11 MULHU.
- reqN_a_i, reqN_b_i  input  XLEN  operands.
- respN_valid_o  output  1  one-cycle result pulse to requester N.
- respN_data_o  output  XLEN  result for requester N.
- mul_req_o  output  1  request to the shared unsigned multiplier; low flushes it.
- mul_a_o, mul_b_o  output  XLEN  unsigned operands to the multiplier.
- mul_ready_i  input  1  multiplier result valid.
- mul_result_i  input  2*XLEN  unsigned product.

Function
REQ-003 SHALL implement the FSM IDLE -> BUSY -> RESP -> IDLE.
REQ-004 IDLE: if any reqN_valid_i is high, SHALL grant exactly one requester, pulse its reqN_ready_o in that same cycle, latch op/a/b/grant id, and move to BUSY.
REQ-005 Arbitration SHALL be round-robin: with both valid, grant the requester not granted last; with one valid, grant it. last_grant SHALL reset to 1, so requester 0 wins the first tie.
REQ-006 reqN_ready_o SHALL be low in BUSY and RESP; a requester holds valid and operands stable until ready.
REQ-007 BUSY: mul_req_o SHALL be high with stable mul_a_o/mul_b_o, and the FSM SHALL stay in BUSY until mul_ready_i=1. No cycle count is assumed.
REQ-008 When mul_ready_i=1 in BUSY, SHALL register the sign-corrected, op-selected result and go to RESP. mul_req_o SHALL be low from RESP onward.
REQ-009 RESP: SHALL assert respN_valid_o for the granted N for exactly one cycle, with respN_data_o valid; then return to IDLE.
REQ-010 RESP and IDLE SHALL guarantee at least one mul_req_o=0 cycle between consecutive multiplications, so the multiplier flushes.
REQ-011 Sign rules: MUL and MULH treat a and b as signed; MULHSU treats a signed and b unsigned; MULHU treats both unsigned.
REQ-012 Signed operands SHALL be sent as magnitude (two's-complement abs). -2^(XLEN-1) SHALL map to unsigned 2^(XLEN-1).
REQ-013 neg = sign(a_eff) XOR sign(b_eff). When neg=1, the 2*XLEN product SHALL be two's-complement negated.
REQ-014 MUL SHALL return product[XLEN-1:0]; MULH, MULHSU and MULHU SHALL return product[2*XLEN-1:XLEN].
REQ-015 Latency: accept at cycle 0, mul_req_o high from cycle 1, resp at the cycle after mul_ready_i.
REQ-016 respN_data_o SHALL hold its last value when not valid; resp1_valid_o and resp0_valid_o SHALL never be high together.

Reset
REQ-017 rst_i=1 SHALL force IDLE on the next edge from any state: mul_req_o=0, all ready/valid outputs 0, data outputs 0, last_grant=1.
REQ-018 A reset during BUSY SHALL drop the in-flight operation with no response to any requester.

Configuration
REQ-019 Macro MUL_ARB_ZERO_SKIP_EN defined: if the latched a or b is zero, the FSM SHALL go IDLE -> RESP directly with result 0, mul_req_o never asserted, response at cycle 1.
REQ-020 Macro MUL_ARB_ZERO_SKIP_EN undefined: zero operands SHALL use the multiplier like any other operands.

Structure
REQ-021 Package mul_arb_pkg SHALL hold the op codes (OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU) and the FSM state encoding (ST_IDLE, ST_BUSY, ST_RESP).
REQ-022 Sub-module mul_sign_fix (combinational: operand abs, neg flag, result negate/select) SHALL be instantiated once.

Verification
REQ-023 Bench with a behavioural multiplier of XLEN=32 latency:
- req0 MUL a=7, b=-3 -> resp0 data 0xFFFFFFEB, mul_a_o=7, mul_b_o=3.
- req1 MULH a=0x80000000, b=0x80000000 -> resp1 data 0x40000000.
- MULHSU a=-1, b=0xFFFFFFFF -> 0xFFFFFFFF; MULHU same operands -> 0xFFFFFFFE.
- Both valid every cycle -> grants alternate 0,1,0,1; first grant 0; no double resp; mul_req_o low >=1 cycle between ops.
- rst_i high mid-BUSY -> next cycle IDLE, mul_req_o=0, no resp. With ZERO_SKIP_EN, a=0 -> resp at cycle 1, mul_req_o never high.
